// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder stimulus/checker harness.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/adder_exp_pipe.sv
// LAT-deep shift register of expected sums; only the valid bits are reset,
// the payload is don't-care whenever its valid bit is low.
module adder_exp_pipe
    import adder_chk_pkg::*;
#(
    parameter int unsigned W   = 64,
    parameter int unsigned LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [W:0]       push_exp,
    input  logic [CNT_W-1:0] push_idx,
    output logic [LAT-1:0]   stage_vld,
    output logic [W:0]       tail_exp,
    output logic [CNT_W-1:0] tail_idx
);

    logic [W:0]       exp_q [LAT];
    logic [CNT_W-1:0] idx_q [LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_vld <= '0;
        end else begin
            stage_vld[0] <= push_valid;
            for (int i = 1; i < LAT; i++) begin
                stage_vld[i] <= stage_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        exp_q[0] <= push_exp;
        idx_q[0] <= push_idx;
        for (int i = 1; i < LAT; i++) begin
            exp_q[i] <= exp_q[i-1];
            idx_q[i] <= idx_q[i-1];
        end
    end

    assign tail_exp = exp_q[LAT-1];
    assign tail_idx = idx_q[LAT-1];

endmodule

// File: rtl/adder_stim_checker.sv
// Drives deterministic operand pairs into a registered adder and scores the
// returned sum/odd flag against a LAT-deep pipeline of expected results.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | issuing one operand pair per clock
// DRAIN | all pairs issued, waiting for the last result to be checked
// DONE  | verdict valid, outputs held until start or reset
module adder_stim_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned   W      = 64,
    parameter int unsigned   LAT    = 2,
    parameter int unsigned   N_VEC  = 16,
    parameter logic [W-1:0]  A_SEED = W'(1),
    parameter logic [W-1:0]  A_STEP = W'(1),
    parameter logic [W-1:0]  B_SEED = W'(2),
    parameter logic [W-1:0]  B_STEP = W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [W:0]       sum_i,
    input  logic             is_odd_i,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_err_o,
    output logic             first_err_vld_o
);

    typedef struct packed {
        logic             valid;
        logic [W:0]       exp;
        logic [CNT_W-1:0] idx;
    } exp_entry_t;

    // Every stage except the one under check.
    localparam logic [LAT-1:0] EARLY_MASK = {LAT{1'b1}} >> 1;

    chk_state_t       state_q;
    logic [W-1:0]     gen_a_q;
    logic [W-1:0]     gen_b_q;
    logic [CNT_W-1:0] vec_cnt_q;

    exp_entry_t       push_ent;
    exp_entry_t       chk_ent;
    logic [LAT-1:0]   stage_vld;
    logic [W:0]       tail_exp;
    logic [CNT_W-1:0] tail_idx;
    logic             chk_fail;
    logic             last_chk;
    logic [CNT_W-1:0] err_nxt;

    assign push_ent = '{valid: (state_q == RUN),
                        exp:   {1'b0, gen_a_q} + {1'b0, gen_b_q},
                        idx:   vec_cnt_q};

    adder_exp_pipe #(
        .W   (W),
        .LAT (LAT)
    ) u_exp_pipe (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_ent.valid),
        .push_exp   (push_ent.exp),
        .push_idx   (push_ent.idx),
        .stage_vld  (stage_vld),
        .tail_exp   (tail_exp),
        .tail_idx   (tail_idx)
    );

    assign chk_ent  = '{valid: stage_vld[LAT-1], exp: tail_exp, idx: tail_idx};
    assign chk_fail = chk_ent.valid &&
                      ((sum_i != chk_ent.exp) || (is_odd_i != chk_ent.exp[0]));
    assign err_nxt  = chk_fail ? sat_inc(err_cnt_o) : err_cnt_o;
    assign last_chk = chk_ent.valid && ((stage_vld & EARLY_MASK) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            gen_a_q         <= '0;
            gen_b_q         <= '0;
            vec_cnt_q       <= '0;
            a_o             <= '0;
            b_o             <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            err_cnt_o       <= '0;
            first_err_o     <= '0;
            first_err_vld_o <= 1'b0;
        end else begin
            if (chk_fail) begin
                err_cnt_o <= err_nxt;
                if (!first_err_vld_o) begin
                    first_err_o     <= chk_ent.idx;
                    first_err_vld_o <= 1'b1;
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q         <= RUN;
                        gen_a_q         <= A_SEED;
                        gen_b_q         <= B_SEED;
                        vec_cnt_q       <= '0;
                        err_cnt_o       <= '0;
                        first_err_o     <= '0;
                        first_err_vld_o <= 1'b0;
                        pass_o          <= 1'b0;
                        busy_o          <= 1'b1;
                        done_o          <= 1'b0;
                    end
                end
                RUN: begin
                    a_o       <= gen_a_q;
                    b_o       <= gen_b_q;
                    gen_a_q   <= gen_a_q + A_STEP;
                    gen_b_q   <= gen_b_q - B_STEP;
                    vec_cnt_q <= vec_cnt_q + CNT_W'(1);
                    if (vec_cnt_q == CNT_W'(N_VEC - 1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The final error update lands on this same edge.
                    if (last_chk) begin
                        state_q <= DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        pass_o  <= (err_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
